// File: rtl/conv3x3_down_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_down_pkg
// Description : Shared accelerator definitions for the 3x3 downsampling
//               convolution stage: pixel and accumulator widths and the
//               frame-control state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package conv3x3_down_pkg;

  localparam int PIX_W = 8;   // signed input pixel / weight / bias width
  localparam int ACC_W = 20;  // signed result width (no saturation)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : conv3x3_down_pkg
`default_nettype wire

// File: rtl/conv3x3_down_if.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_down_if
// Description : Control, pixel-stream, coefficient and result bundle of the
//               3x3 downsampling convolution.
// Ports       : master - frame source (drives start/pixels/weights/geometry,
//                        receives pixel/out_valid/busy/done)
//               slave  - convolution engine (opposite directions)
// Revision    : 1.0 - initial release
// ============================================================================
interface conv3x3_down_if;
  import conv3x3_down_pkg::*;

  logic                    start;
  logic signed [PIX_W-1:0] in;
  logic                    in_valid;
  logic signed [PIX_W-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic signed [PIX_W-1:0] bias;
  logic        [7:0]       width;
  logic        [7:0]       height;
  logic                    stride2;
  logic signed [ACC_W-1:0] pixel;
  logic                    out_valid;
  logic                    busy;
  logic                    done;

  modport master (
    output start, in, in_valid,
    output w1, w2, w3, w4, w5, w6, w7, w8, w9, bias,
    output width, height, stride2,
    input  pixel, out_valid, busy, done
  );

  modport slave (
    input  start, in, in_valid,
    input  w1, w2, w3, w4, w5, w6, w7, w8, w9, bias,
    input  width, height, stride2,
    output pixel, out_valid, busy, done
  );

endinterface : conv3x3_down_if
`default_nettype wire

// File: rtl/conv3x3_down_linebuf.sv
`default_nettype none
// ============================================================================
// Module      : conv_linebuf
// Description : Single-line delay FIFO. Each enabled cycle it returns the
//               entry written exactly len_i enabled cycles earlier and stores
//               din_i in its place (circular buffer, pointer wraps at len-1).
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset (pointer only)
//               clr_i  - restart the pointer for a new frame
//               en_i   - advance on an accepted pixel
//               len_i  - active line length (<= DEPTH)
//               din_i  - pixel entering the line
//               dout_o - pixel that entered one line earlier
// Revision    : 1.0 - initial release
// ============================================================================
module conv_linebuf
  import conv3x3_down_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    clr_i,
  input  wire logic                    en_i,
  input  wire logic        [7:0]       len_i,
  input  wire logic signed [PIX_W-1:0] din_i,
  output      logic signed [PIX_W-1:0] dout_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [PIX_W-1:0] mem_q [DEPTH];
  logic        [PTR_W-1:0] ptr_q;
  logic        [PTR_W-1:0] ptr_d;
  logic                    ptr_wrap;

  assign ptr_wrap = (ptr_q == PTR_W'(len_i - 8'd1));
  assign ptr_d    = ptr_wrap ? '0 : ptr_q + PTR_W'(1);

  // Read-before-write: the slot at the pointer holds the oldest entry.
  assign dout_o = mem_q[ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is left unreset; stale entries are never used because windows
  // are only formed once two full lines of the current frame have arrived.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule : conv_linebuf
`default_nettype wire

// File: rtl/conv3x3_down.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_down
// Description : Streaming valid (unpadded) 3x3 correlation with optional
//               stride 2. Pixels arrive in raster order; two line buffers
//               supply the two previous rows and a small window register
//               supplies the two previous columns. One result per completed
//               window, one cycle after the completing pixel is accepted.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-low reset
//               bus  - conv3x3_down_if.slave: start, in/in_valid, w1..w9,
//                      bias, width, height, stride2 in; pixel, out_valid,
//                      busy, done out
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_down
  import conv3x3_down_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 128,
  parameter int IMAGE_HEIGHT = 128
) (
  input  wire logic       clk,
  input  wire logic       rst,
  conv3x3_down_if.slave   bus
);

  localparam int COL_W = (IMAGE_WIDTH  > 2) ? $clog2(IMAGE_WIDTH)  : 2;
  localparam int ROW_W = (IMAGE_HEIGHT > 2) ? $clog2(IMAGE_HEIGHT) : 2;

  // --------------------------------------------------------------------------
  // Frame control registers
  // --------------------------------------------------------------------------
  state_t                  state_q;
  logic        [COL_W-1:0] col_q;
  logic        [ROW_W-1:0] row_q;
  logic        [7:0]       width_q;
  logic        [7:0]       height_q;
  logic                    stride2_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    out_valid_q;
  logic signed [ACC_W-1:0] pixel_q;
  logic signed [ACC_W-1:0] pixel_d;

  logic accept;
  logic frame_start;
  logic col_last;
  logic row_last;
  logic phase_ok;
  logic complete;

  assign frame_start = (state_q == ST_IDLE) && bus.start;
  assign accept      = (state_q == ST_RUN) && bus.in_valid;
  assign col_last    = (col_q == COL_W'(width_q  - 8'd1));
  assign row_last    = (row_q == ROW_W'(height_q - 8'd1));
  // (row-2) and (col-2) even is the same as row and col even.
  assign phase_ok    = !stride2_q || (!row_q[0] && !col_q[0]);
  assign complete    = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2))
                       && phase_ok;

  // --------------------------------------------------------------------------
  // Line buffers: stage 0 delays the input by one line, stage 1 by two.
  // --------------------------------------------------------------------------
  logic signed [PIX_W-1:0] lb_din  [2];
  logic signed [PIX_W-1:0] lb_dout [2];

  assign lb_din[0] = bus.in;
  assign lb_din[1] = lb_dout[0];

  for (genvar g = 0; g < 2; g++) begin : g_linebuf
    conv_linebuf #(
      .DEPTH (IMAGE_WIDTH)
    ) u_linebuf (
      .clk    (clk),
      .rst_n  (rst),
      .clr_i  (frame_start),
      .en_i   (accept),
      .len_i  (width_q),
      .din_i  (lb_din[g]),
      .dout_o (lb_dout[g])
    );
  end

  // --------------------------------------------------------------------------
  // Window: the register keeps columns col-2 and col-1 of rows row-2..row;
  // the incoming column completes the 3x3 window combinationally so the
  // result can be registered on the accepting edge.
  // Row index 0 = top (row-2), 2 = bottom (current row).
  // --------------------------------------------------------------------------
  logic signed [PIX_W-1:0] hist_q [3][2];
  logic signed [PIX_W-1:0] win_d  [3][3];
  logic signed [PIX_W-1:0] col_new [3];
  logic signed [PIX_W-1:0] w_arr  [9];

  assign col_new[0] = lb_dout[1];
  assign col_new[1] = lb_dout[0];
  assign col_new[2] = bus.in;

  assign w_arr[0] = bus.w1;
  assign w_arr[1] = bus.w2;
  assign w_arr[2] = bus.w3;
  assign w_arr[3] = bus.w4;
  assign w_arr[4] = bus.w5;
  assign w_arr[5] = bus.w6;
  assign w_arr[6] = bus.w7;
  assign w_arr[7] = bus.w8;
  assign w_arr[8] = bus.w9;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = hist_q[r][0];
      win_d[r][1] = hist_q[r][1];
      win_d[r][2] = col_new[r];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        hist_q[r][0] <= hist_q[r][1];
        hist_q[r][1] <= col_new[r];
      end
    end
  end

  // Nine signed 8x8 products plus sign-extended bias, wrapped to ACC_W.
  logic signed [2*PIX_W-1:0] prod;

  always_comb begin
    prod    = '0;
    pixel_d = {{(ACC_W-PIX_W){bus.bias[PIX_W-1]}}, bus.bias};
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        prod    = win_d[r][c] * w_arr[r*3+c];
        pixel_d = pixel_d + {{(ACC_W-2*PIX_W){prod[2*PIX_W-1]}}, prod};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      stride2_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      pixel_q     <= '0;
    end else begin
      out_valid_q <= complete;
      if (complete) begin
        pixel_q <= pixel_d;
      end
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q   <= ST_RUN;
            busy_q    <= 1'b1;
            width_q   <= bus.width;
            height_q  <= bus.height;
            stride2_q <= bus.stride2;
            col_q     <= '0;
            row_q     <= '0;
          end
        end

        ST_RUN: begin
          if (accept) begin
            if (col_last) begin
              col_q <= '0;
              row_q <= row_q + ROW_W'(1);
            end else begin
              col_q <= col_q + COL_W'(1);
            end
            if (col_last && row_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pixel     = pixel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule : conv3x3_down
`default_nettype wire

// File: tb/tb_conv3x3_down.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_down
// Description : Self-checking bench for conv3x3_down: directed vector table,
//               reset/idle sequences and random frames against a reference
//               computed directly from the frame contents.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_down;
  import conv3x3_down_pkg::*;

  localparam int IMG_W = 16;
  localparam int IMG_H = 16;
  localparam int N_VEC = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv3x3_down_if bus ();

  conv3x3_down #(
    .IMAGE_WIDTH  (IMG_W),
    .IMAGE_HEIGHT (IMG_H)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  typedef struct packed {
    int w;
    int h;
    bit s2;
    bit ramp;    // 1: pixel = row*w + col, 0: constant pval
    int pval;
    bit center;  // 1: only w5 = wval, 0: all weights = wval
    int wval;
    int bias;
    bit gaps;
    int n;
  } vec_t;

  vec_t vecs    [N_VEC];
  int   exp_tab [N_VEC][9];

  int pix [IMG_H][IMG_W];
  int wts [9];
  int bias_v;
  int exp_q [$];
  int got_q [$];
  int done_cnt;
  int done_at;
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(string name, int act, int expv);
    chk_cnt++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Output monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    if (bus.out_valid) got_q.push_back(int'($signed(bus.pixel)));
    if (bus.done) begin
      done_cnt++;
      done_at = got_q.size();
    end
  end

  task automatic set_weights();
    bus.w1 = 8'(wts[0]); bus.w2 = 8'(wts[1]); bus.w3 = 8'(wts[2]);
    bus.w4 = 8'(wts[3]); bus.w5 = 8'(wts[4]); bus.w6 = 8'(wts[5]);
    bus.w7 = 8'(wts[6]); bus.w8 = 8'(wts[7]); bus.w9 = 8'(wts[8]);
    bus.bias = 8'(bias_v);
  endtask

  // Reference: every window position on the stride grid, summed directly.
  task automatic model(int w, int h, bit s2);
    int st;
    int acc;
    st = s2 ? 2 : 1;
    exp_q.delete();
    for (int r = 0; r + 2 < h; r += st) begin
      for (int c = 0; c + 2 < w; c += st) begin
        acc = bias_v;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += wts[i*3+j] * pix[r+i][c+j];
        exp_q.push_back(acc);
      end
    end
  endtask

  // Drives one full frame and compares collected outputs against exp_q.
  task automatic run_frame(int w, int h, bit s2, bit gaps);
    got_q.delete();
    done_cnt = 0;
    done_at  = -1;
    set_weights();
    @(negedge clk);
    bus.start = 1'b1; bus.width = 8'(w); bus.height = 8'(h); bus.stride2 = s2;
    @(negedge clk);
    bus.start = 1'b0;
    #1 chk("busy_in_run", int'(bus.busy), 1);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gaps) begin
          bus.in_valid = 1'b0;
          bus.in       = 8'(r + c + 77);
          @(negedge clk);
        end
        bus.in       = 8'(pix[r][c]);
        bus.in_valid = 1'b1;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && done_cnt == 0; k++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("out_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("pixel_value", got_q[i], exp_q[i]);
    if (exp_q.size() > 0) begin
      chk("done_with_last", done_at, exp_q.size());
      chk("pixel_hold", int'($signed(bus.pixel)), exp_q[exp_q.size()-1]);
    end
    chk("busy_after_done", int'(bus.busy), 0);
  endtask

  task automatic load_frame(vec_t v);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = v.ramp ? (r * v.w + c) : v.pval;
    for (int i = 0; i < 9; i++)
      wts[i] = (v.center && i != 4) ? 0 : v.wval;
    bias_v = v.bias;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.in = '0; bus.in_valid = 1'b0;
    bus.w1 = '0; bus.w2 = '0; bus.w3 = '0; bus.w4 = '0; bus.w5 = '0;
    bus.w6 = '0; bus.w7 = '0; bus.w8 = '0; bus.w9 = '0; bus.bias = '0;
    bus.width = '0; bus.height = '0; bus.stride2 = 1'b0;
    done_cnt = 0; done_at = -1;

    vecs[0] = '{w:4, h:4, s2:0, ramp:0, pval:1,    center:0, wval:1,    bias:0,    gaps:0, n:4};
    vecs[1] = '{w:5, h:5, s2:0, ramp:1, pval:0,    center:1, wval:1,    bias:0,    gaps:0, n:9};
    vecs[2] = '{w:5, h:5, s2:1, ramp:1, pval:0,    center:1, wval:1,    bias:0,    gaps:0, n:4};
    vecs[3] = '{w:3, h:3, s2:0, ramp:0, pval:-128, center:0, wval:-128, bias:127,  gaps:0, n:1};
    vecs[4] = '{w:3, h:3, s2:0, ramp:0, pval:-128, center:0, wval:-128, bias:-128, gaps:0, n:1};
    vecs[5] = '{w:5, h:5, s2:0, ramp:1, pval:0,    center:1, wval:1,    bias:0,    gaps:1, n:9};
    vecs[6] = '{w:2, h:5, s2:0, ramp:0, pval:1,    center:0, wval:1,    bias:0,    gaps:0, n:0};
    vecs[7] = '{w:7, h:6, s2:1, ramp:0, pval:1,    center:0, wval:1,    bias:-3,   gaps:0, n:6};
    exp_tab = '{
      '{9, 9, 9, 9, 0, 0, 0, 0, 0},
      '{6, 7, 8, 11, 12, 13, 16, 17, 18},
      '{6, 8, 16, 18, 0, 0, 0, 0, 0},
      '{147583, 0, 0, 0, 0, 0, 0, 0, 0},
      '{147328, 0, 0, 0, 0, 0, 0, 0, 0},
      '{6, 7, 8, 11, 12, 13, 16, 17, 18},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0},
      '{6, 6, 6, 6, 6, 6, 0, 0, 0}
    };

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_done",      int'(bus.done), 0);
    chk("rst_pixel",     int'($signed(bus.pixel)), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // in_valid in IDLE has no effect
    got_q.delete();
    bus.in = 8'sd5; bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("idle_no_output", got_q.size(), 0);
    chk("idle_not_busy",  int'(bus.busy), 0);

    // Directed vector table
    for (int i = 0; i < N_VEC; i++) begin
      load_frame(vecs[i]);
      exp_q.delete();
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(exp_tab[i][k]);
      run_frame(vecs[i].w, vecs[i].h, vecs[i].s2, vecs[i].gaps);
    end

    // Mid-frame asynchronous reset on a ramp frame
    load_frame(vecs[1]);
    set_weights();
    @(negedge clk);
    bus.start = 1'b1; bus.width = 8'd5; bus.height = 8'd5; bus.stride2 = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      bus.in = 8'(k); bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", int'(bus.out_valid), 1);
    chk("pre_rst_pixel",     int'($signed(bus.pixel)), 6);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_busy",      int'(bus.busy), 0);
    chk("mid_rst_pixel",     int'($signed(bus.pixel)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_frame(vecs[0]);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(9);
    run_frame(4, 4, 1'b0, 1'b0);

    // Random frames against the reference
    for (int f = 0; f < 12; f++) begin
      int w;
      int h;
      bit s2;
      bit gp;
      w  = int'($urandom_range(1, 10));
      h  = int'($urandom_range(1, 10));
      s2 = 1'($urandom_range(0, 1));
      gp = 1'($urandom_range(0, 1));
      for (int r = 0; r < IMG_H; r++)
        for (int c = 0; c < IMG_W; c++)
          pix[r][c] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < 9; i++) wts[i] = int'($urandom_range(0, 255)) - 128;
      bias_v = int'($urandom_range(0, 255)) - 128;
      model(w, h, s2);
      run_frame(w, h, s2, gp);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_conv3x3_down
`default_nettype wire

// File: doc/conv3x3_down.md
CONV3X3_DOWN -- requirements
Module: conv3x3_down

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 128: maximum line length held in the line buffers.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 128: maximum frame height accepted.
REQ-003 SHALL have one clock and an asynchronous active-low reset. Port list:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begins a frame.
- in  input  8  signed input pixel.
- in_valid  input  1  `in` is valid this cycle.
- w9..w1  input  8 each  signed kernel weights.
- bias  input  8  signed bias.
- width  input  8  frame width.
- height  input  8  frame height.
- stride2  input  1  1 selects stride 2; 0 selects stride 1.
- pixel  output  20  signed result.
- out_valid  output  1  `pixel` is valid this cycle.
- busy  output  1  frame in progress.
- done  output  1  one-cycle end-of-frame pulse.

Function
REQ-004 SHALL compute a valid (unpadded) 3x3 correlation, the downsampling counterpart of the transposed-convolution stage. Weight positions relative to the window top-left:
- w1 (0,0), w2 (0,1), w3 (0,2)
- w4 (1,0), w5 (1,1), w6 (1,2)
- w7 (2,0), w8 (2,1), w9 (2,2)
REQ-005 SHALL form pixel as the sum of nine signed 8x8 products plus sign-extended bias, in 20 bits with no saturation. The worst case is 147583, which fits.
REQ-006 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE->RUN on start. On that edge, latch width, height and stride2, and clear the row and column counters.
REQ-007 SHALL accept pixels in RUN only when in_valid=1, in raster order.
- Column counter wraps at width-1. Row counter then increments.
- Gaps in in_valid stall the frame with no effect.
REQ-008 SHALL ignore in_valid in IDLE and DONE, and ignore start in RUN and DONE.
REQ-009 SHALL keep the two previous input rows in two line buffers and a 3x3 window register, shifted on each accepted pixel.
REQ-010 SHALL complete a window when the accepted pixel has row>=2 and col>=2.
- With stride2=1, additionally (row-2) and (col-2) must both be even.
REQ-011 SHALL assert out_valid for exactly one cycle, carrying pixel, on the cycle after the accepting edge of a completing pixel. Fixed latency is 1, with no backpressure.
REQ-012 SHALL produce outputs per frame:
- stride 1: (width-2)*(height-2) outputs.
- stride 2: (floor((width-3)/2)+1)*(floor((height-3)/2)+1) outputs.
REQ-013 SHALL, when width<3 or height<3, consume width*height pixels, emit no outputs and still finish normally.
REQ-014 SHALL move RUN->DONE on acceptance of pixel (height-1, width-1).
- In DONE, done=1 for one cycle, coincident with the final out_valid if one exists.
- DONE->IDLE unconditionally on the next edge.
REQ-015 SHALL drive busy=1 in RUN and DONE, and 0 in IDLE.
REQ-016 SHALL require width<=IMAGE_WIDTH and height<=IMAGE_HEIGHT. Behaviour for larger values is undefined.
REQ-017 SHALL hold pixel at its last value when out_valid=0.

Reset
REQ-018 SHALL, on rst=0 at any time including mid-frame, immediately:
- enter IDLE;
- clear the counters;
- clear out_valid, done and busy;
- clear pixel to 0.
REQ-019 SHALL not require line-buffer contents to be cleared by reset, because windows are gated by the row and column counters.
REQ-020 SHALL accept start on the first clock edge after rst deasserts.

Structure
REQ-021 SHALL place the following in the shared accelerator package:
- PIX_W=8
- ACC_W=20
- the IDLE/RUN/DONE state encoding
REQ-022 SHALL instantiate one sub-module, conv_linebuf. It is a parameterised single-line FIFO of IMAGE_WIDTH signed 8-bit entries, advanced on accepted pixels, and is instantiated twice.

Verification
REQ-023 Scenario "all ones": 4x4 frame, all pixels 1, w*=1, bias=0, stride 1.
- Expect 4 outputs of 9.
- Expect done coincident with the 4th out_valid.
REQ-024 Scenario "identity ramp": 5x5 frame with pixel=row*5+col, w5=1, other weights 0, bias=0, stride 1.
- Expect outputs 6,7,8,11,12,13,16,17,18.
REQ-025 Scenario "stride 2": same ramp with stride2=1.
- Expect exactly 4 outputs: 6,8,16,18.
REQ-026 Scenario "extreme values": 3x3 frame, all pixels -128, all weights -128, bias=127.
- Expect a single output of 147583.
- Separately, with bias=-128: expect 147328.
REQ-027 Scenario "gaps and reset": drive the identity ramp with in_valid toggling every other cycle.
- Expect outputs identical to REQ-024.
- Then assert rst mid-frame: expect out_valid=0, busy=0 immediately.
- A following 4x4 all-ones frame must give 4 outputs of 9.
